// File: rtl/sent_rx_frame_assembler.sv
// SENT fast-channel frame assembler.
// Collects status, data and CRC nibbles after each sync pulse, checks the
// SAE J2716 CRC4 and packs good frames into bytes for the RX FIFO. Short,
// corrupted or overrun frames are dropped and flagged with a one-cycle pulse.
module sent_rx_frame_assembler #(
    parameter int DATA_NIBBLES = 6
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    input  logic       sync_in,
    input  logic       pause_in,
    input  logic       chan_err,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wr_data,
    output logic       frame_done,
    output logic       crc_err,
    output logic       len_err,
    output logic       ovr_err,
    output logic [7:0] frame_cnt
);

    localparam int         NB       = 1 + DATA_NIBBLES / 2;
    localparam int         NIB_W    = $clog2(DATA_NIBBLES);
    localparam int         BYTE_W   = $clog2(NB);
    localparam logic [3:0] CRC_SEED = 4'h5;

    typedef enum logic [2:0] {
        IDLE,
        STATUS,
        DATA,
        CRC,
        PUSH
    } state_t;

    state_t            state;
    logic [3:0]        crc;
    logic [NIB_W-1:0]  nib_idx;
    logic [BYTE_W-1:0] byte_idx;
    logic [3:0]        status_nib;
    logic [3:0]        dnib [DATA_NIBBLES];
    logic [7:0]        frame_bytes [NB];

    // One bit of the x^4+x^3+x^2+1 LFSR, MSB-first.
    function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic b);
        return {c[2:0], b} ^ (c[3] ? 4'b1101 : 4'b0000);
    endfunction

    function automatic logic [3:0] crc_nibble(input logic [3:0] c, input logic [3:0] n);
        logic [3:0] r;
        r = crc_bit(c, n[3]);
        r = crc_bit(r, n[2]);
        r = crc_bit(r, n[1]);
        r = crc_bit(r, n[0]);
        return r;
    endfunction

    // Strobe priority: chan_err > sync_in > pause_in > nib_valid.
    logic collecting;
    logic ev_sync;
    logic ev_pause;
    logic ev_nib;
    logic crc_match;

    assign collecting = (state == STATUS) || (state == DATA) || (state == CRC);
    assign ev_sync    = sync_in  && !chan_err;
    assign ev_pause   = pause_in && !chan_err && !sync_in;
    assign ev_nib     = nib_valid && !chan_err && !sync_in && !pause_in;
    assign crc_match  = (crc_nibble(crc, 4'h0) == nib_data);

    // Frame FSM, indices, CRC, frame counter and registered error pulses.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            crc       <= CRC_SEED;
            nib_idx   <= '0;
            byte_idx  <= '0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            ovr_err   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            crc_err <= 1'b0;
            len_err <= 1'b0;
            ovr_err <= 1'b0;
            if (collecting && (chan_err || ev_pause)) begin
                len_err <= 1'b1;
                state   <= IDLE;
            end else if (collecting && ev_sync) begin
                len_err <= 1'b1;
                state   <= STATUS;
                crc     <= CRC_SEED;
                nib_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev_sync) begin
                            state   <= STATUS;
                            crc     <= CRC_SEED;
                            nib_idx <= '0;
                        end
                    end
                    STATUS: begin
                        if (ev_nib) state <= DATA;
                    end
                    DATA: begin
                        if (ev_nib) begin
                            crc     <= crc_nibble(crc, nib_data);
                            nib_idx <= nib_idx + NIB_W'(1);
                            if (nib_idx == NIB_W'(DATA_NIBBLES - 1)) state <= CRC;
                        end
                    end
                    CRC: begin
                        if (ev_nib) begin
                            byte_idx <= '0;
                            if (crc_match) begin
                                state <= PUSH;
                            end else begin
                                crc_err <= 1'b1;
                                state   <= IDLE;
                            end
                        end
                    end
                    PUSH: begin
                        if (sync_in) ovr_err <= 1'b1;
                        if (!fifo_full) begin
                            if (byte_idx == BYTE_W'(NB - 1)) begin
                                byte_idx  <= '0;
                                frame_cnt <= frame_cnt + 8'd1;
                                state     <= IDLE;
                            end else begin
                                byte_idx <= byte_idx + BYTE_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Nibble capture for the frame being received.
    // NOTE: this storage has no reset on purpose: it is always rewritten before
    // PUSH reads it, and the output mux forces zero outside PUSH.
    always_ff @(posedge PCLK) begin
        if (ev_nib && !collecting_abort()) begin
            if (state == STATUS) status_nib <= nib_data;
            if (state == DATA)   dnib[nib_idx] <= nib_data;
        end
    end

    // Abort strobes already mask ev_nib; kept as a function for readability.
    function automatic logic collecting_abort();
        return 1'b0;
    endfunction

    // Byte packing: byte0 carries the status nibble, later bytes pair data
    // nibbles with the first-received nibble in the high half.
    assign frame_bytes[0] = {4'h0, status_nib};
    for (genvar k = 1; k < NB; k++) begin : g_pack
        assign frame_bytes[k] = {dnib[2*k-2], dnib[2*k-1]};
    end

    // FIFO write side is combinational so a deasserted fifo_full writes at once.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 8'h00;
        frame_done   = 1'b0;
        if (state == PUSH) begin
            fifo_wr_en   = !fifo_full;
            fifo_wr_data = frame_bytes[byte_idx];
            frame_done   = !fifo_full && (byte_idx == BYTE_W'(NB - 1));
        end
    end

endmodule

// File: tb/tb_sent_rx_frame_assembler.sv
// Self-checking bench for sent_rx_frame_assembler (DATA_NIBBLES = 6).
// Expected FIFO bytes are queued when a frame is driven and popped by a
// negedge monitor whenever the DUT writes.
module tb_sent_rx_frame_assembler;

    localparam int NB = 4;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       nib_valid, sync_in, pause_in, chan_err, fifo_full;
    logic [3:0] nib_data;
    logic       fifo_wr_en, frame_done, crc_err, len_err, ovr_err;
    logic [7:0] fifo_wr_data, frame_cnt;

    sent_rx_frame_assembler #(.DATA_NIBBLES(6)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .nib_valid(nib_valid), .nib_data(nib_data),
        .sync_in(sync_in), .pause_in(pause_in), .chan_err(chan_err),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .frame_done(frame_done), .crc_err(crc_err), .len_err(len_err),
        .ovr_err(ovr_err), .frame_cnt(frame_cnt)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  status;
        logic [23:0] data;
        logic [3:0]  crc;
        logic        good;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_byte_t;

    exp_byte_t exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_crc_err = 0, n_len_err = 0, n_ovr_err = 0;
    int        exp_cnt  = 0;
    frame_t    f1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC as long division of {data, 0000} by 5'b11101, seeded with 5.
    function automatic logic [3:0] crc_model(input logic [23:0] data);
        logic [4:0]  r;
        logic [27:0] msg;
        r   = 5'h05;
        msg = {data, 4'h0};
        for (int i = 27; i >= 0; i--) begin
            r = {r[3:0], msg[i]};
            if (r[4]) r = r ^ 5'b11101;
        end
        return r[3:0];
    endfunction

    // Monitor: compare every FIFO write against the scoreboard, count pulses.
    always @(negedge PCLK) begin
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, fifo_wr_data}, 32'hFFFF_FFFF);
            end else begin
                exp_byte_t e;
                e = exp_q.pop_front();
                check("wr_data", {24'h0, fifo_wr_data}, {24'h0, e.data});
                check("frame_done", {31'h0, frame_done}, {31'h0, e.last});
            end
        end else if (frame_done) begin
            check("frame_done_without_write", 32'd1, 32'd0);
        end
        if (crc_err) n_crc_err++;
        if (len_err) n_len_err++;
        if (ovr_err) n_ovr_err++;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_valid = 1'b1;
        nib_data  = n;
        tick();
        nib_valid = 1'b0;
    endtask

    task automatic send_sync();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic push_expected(input frame_t f, input int nbytes);
        logic [7:0] b [NB];
        b[0] = {4'h0, f.status};
        b[1] = f.data[23:16];
        b[2] = f.data[15:8];
        b[3] = f.data[7:0];
        for (int k = 0; k < nbytes; k++) exp_q.push_back('{b[k], (k == NB - 1)});
        if (nbytes == NB) exp_cnt++;
    endtask

    task automatic send_body(input frame_t f);
        logic [23:0] d;
        d = f.data;
        send_nib(f.status);
        for (int i = 0; i < 6; i++) begin
            send_nib(d[23:20]);
            d = d << 4;
        end
        send_nib(f.crc);
    endtask

    task automatic send_frame(input frame_t f);
        send_sync();
        if (f.good) push_expected(f, NB);
        send_body(f);
    endtask

    // Wait for the scoreboard to empty; returns the number of negedges taken.
    task automatic wait_drain(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check("drain_timeout", {31'h0, (exp_q.size() != 0)}, 32'd0);
    endtask

    frame_t vecs[5];
    int     n;

    initial begin
        PRESETn = 1'b0; nib_valid = 1'b0; nib_data = 4'h0; sync_in = 1'b0;
        pause_in = 1'b0; chan_err = 1'b0; fifo_full = 1'b0;

        vecs[0] = '{4'hA, 24'h123456, 4'h2, 1'b1};
        vecs[1] = '{4'h0, 24'h000000, 4'h5, 1'b1};
        vecs[2] = '{4'h0, 24'h000000, 4'h4, 1'b0};
        vecs[3] = '{4'hF, 24'hFFFFFF, crc_model(24'hFFFFFF), 1'b1};
        vecs[4] = '{4'h3, 24'h9A5C01, crc_model(24'h9A5C01) ^ 4'h1, 1'b0};
        f1 = vecs[0];

        // Reset state.
        repeat (2) tick();
        check("rst_wr_en", {31'h0, fifo_wr_en}, 32'd0);
        check("rst_wr_data", {24'h0, fifo_wr_data}, 32'd0);
        check("rst_errs", {29'h0, crc_err, len_err, ovr_err}, 32'd0);
        check("rst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        PRESETn = 1'b1;
        tick();

        // Table-driven frames: good ones drain in NB consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i]);
            if (vecs[i].good) begin
                check("first_write_latency", {31'h0, fifo_wr_en}, 32'd1);
                wait_drain(n);
                check("push_cycles", n, NB);
                tick();
                check("frame_cnt", {24'h0, frame_cnt}, exp_cnt);
            end else begin
                check("crc_err_pulse", {31'h0, crc_err}, 32'd1);
                tick();
                check("crc_err_width", {31'h0, crc_err}, 32'd0);
                check("no_write_bad_crc", {31'h0, fifo_wr_en}, 32'd0);
            end
            repeat (2) tick();
        end

        // FIFO full for 5 cycles at the start of PUSH.
        fifo_full = 1'b1;
        send_frame(f1);
        for (int i = 0; i < 5; i++) begin
            check("stall_wr_en", {31'h0, fifo_wr_en}, 32'd0);
            check("stall_wr_data", {24'h0, fifo_wr_data}, 32'h0A);
            tick();
        end
        fifo_full = 1'b0;
        wait_drain(n);
        check("stall_push_cycles", n, NB);
        tick();
        check("stall_frame_cnt", {24'h0, frame_cnt}, exp_cnt);

        // Frame cut short by sync after 3 nibbles; only the second is written.
        send_sync();
        send_nib(4'hA); send_nib(4'h1); send_nib(4'h2);
        send_sync();
        check("short_len_err", {31'h0, len_err}, 32'd1);
        push_expected(f1, NB);
        send_body(f1);
        wait_drain(n);
        tick();
        check("short_frame_cnt", {24'h0, frame_cnt}, exp_cnt);

        // Sync during stalled PUSH: overrun flagged, frame still completes.
        fifo_full = 1'b1;
        send_frame(f1);
        send_sync();
        check("ovr_err_pulse", {31'h0, ovr_err}, 32'd1);
        tick();
        check("ovr_err_width", {31'h0, ovr_err}, 32'd0);
        send_nib(4'h7);
        fifo_full = 1'b0;
        wait_drain(n);
        check("ovr_push_cycles", n, NB);
        tick();
        check("ovr_frame_cnt", {24'h0, frame_cnt}, exp_cnt);
        send_body(f1);                    // no sync: must be ignored
        repeat (5) tick();
        check("ignored_frame_cnt", {24'h0, frame_cnt}, exp_cnt);
        send_frame(f1);
        wait_drain(n);
        tick();
        check("post_ovr_frame_cnt", {24'h0, frame_cnt}, exp_cnt);

        // Asynchronous reset after the second byte is written.
        send_sync();
        push_expected(f1, 2);
        send_body(f1);
        @(negedge PCLK); tick();
        @(negedge PCLK); tick();
        PRESETn = 1'b0;
        #1;
        check("arst_wr_en", {31'h0, fifo_wr_en}, 32'd0);
        check("arst_wr_data", {24'h0, fifo_wr_data}, 32'd0);
        check("arst_frame_done", {31'h0, frame_done}, 32'd0);
        check("arst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        check("arst_queue", exp_q.size(), 0);
        exp_cnt = 0;
        repeat (2) tick();
        PRESETn = 1'b1;
        tick();
        send_frame(f1);
        wait_drain(n);
        check("arst_push_cycles", n, NB);
        tick();
        check("arst_frame_cnt_after", {24'h0, frame_cnt}, exp_cnt);

        // Priority: pause beats nib_valid; chan_err beats sync.
        send_sync();
        send_nib(4'hA);
        pause_in = 1'b1; nib_valid = 1'b1; nib_data = 4'h1;
        tick();
        pause_in = 1'b0; nib_valid = 1'b0;
        check("pause_len_err", {31'h0, len_err}, 32'd1);
        send_sync();
        send_nib(4'hA);
        chan_err = 1'b1; sync_in = 1'b1;
        tick();
        chan_err = 1'b0; sync_in = 1'b0;
        check("chan_len_err", {31'h0, len_err}, 32'd1);
        send_body(f1);                    // would complete a frame if sync had won
        repeat (5) tick();
        check("chan_frame_cnt", {24'h0, frame_cnt}, exp_cnt);

        // Pulse totals seen by the monitor.
        check("total_crc_err", n_crc_err, 2);
        check("total_len_err", n_len_err, 3);
        check("total_ovr_err", n_ovr_err, 1);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
